// File: rtl/dma_buffer_datapath.sv
// DMA buffer datapath with three independent blocks: a FIFO with pointer
// retry, a loadable register and a loadable wrapping counter.
module dma_buffer_datapath #(
  parameter int unsigned ADD_LEN         = 16,
  parameter int unsigned DATA_LEN        = 16,
  parameter int unsigned FIFO_DEPTH      = 5,
  parameter int unsigned FIFO_DIV_FACTOR = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifo_en,
  input  logic                fifo_wr_rd,
  input  logic                fifo_clr,
  input  logic                fifo_old_add_flag,
  input  logic [DATA_LEN-1:0] fifo_in,
  output logic [DATA_LEN-1:0] fifo_out,
  output logic                full,
  output logic                empty,
  output logic                empty_partial,
  input  logic                reg_en,
  input  logic                reg_clr,
  input  logic [ADD_LEN-1:0]  reg_in,
  output logic [ADD_LEN-1:0]  reg_out,
  input  logic                cnt_en,
  input  logic                cnt_load,
  input  logic                cnt_clr,
  input  logic [ADD_LEN-1:0]  cnt_in,
  output logic [ADD_LEN-1:0]  cnt,
  output logic                end_cnt
);

  localparam int unsigned OCC_W       = FIFO_DEPTH + 1;
  localparam int unsigned DEPTH_WORDS = 1 << FIFO_DEPTH;
  localparam int unsigned PART_WORDS  = 1 << (FIFO_DEPTH - FIFO_DIV_FACTOR);

  logic [DATA_LEN-1:0]   mem_q [DEPTH_WORDS];
  logic                  mem_we;

  logic [FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [DATA_LEN-1:0]   fifo_out_q, fifo_out_d;
  logic                  flag_q, flag_d;
  logic [ADD_LEN-1:0]    reg_q, reg_d;
  logic [ADD_LEN-1:0]    cnt_q, cnt_d;
  logic                  retry;

  assign full          = (occ_q == OCC_W'(DEPTH_WORDS));
  assign empty         = (occ_q == '0);
  assign empty_partial = (occ_q <= OCC_W'(PART_WORDS));
  assign end_cnt       = &cnt_q;
  assign fifo_out      = fifo_out_q;
  assign reg_out       = reg_q;
  assign cnt           = cnt_q;

  // Retry acts only on the rising edge of the flag.
  assign retry = fifo_old_add_flag & ~flag_q;

  // FIFO next state: flush beats retry, retry beats normal access.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    fifo_out_d = fifo_out_q;
    mem_we     = 1'b0;
    flag_d     = fifo_old_add_flag;
    if (fifo_clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      fifo_out_d = '0;
    end else if (retry) begin
      if (fifo_wr_rd) begin
        if (!empty) begin
          wr_ptr_d = wr_ptr_q - FIFO_DEPTH'(1);
          occ_d    = occ_q - OCC_W'(1);
        end
      end else if (!full) begin
        rd_ptr_d = rd_ptr_q - FIFO_DEPTH'(1);
        occ_d    = occ_q + OCC_W'(1);
      end
    end else if (fifo_en) begin
      if (fifo_wr_rd) begin
        if (!full) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + FIFO_DEPTH'(1);
          occ_d    = occ_q + OCC_W'(1);
        end
      end else if (!empty) begin
        fifo_out_d = mem_q[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + FIFO_DEPTH'(1);
        occ_d      = occ_q - OCC_W'(1);
      end
    end
  end

  // Register and counter next state.
  always_comb begin
    reg_d = reg_q;
    cnt_d = cnt_q;
    if (reg_clr)     reg_d = '0;
    else if (reg_en) reg_d = reg_in;
    if (cnt_clr)       cnt_d = '0;
    else if (cnt_load) cnt_d = cnt_in;
    else if (cnt_en)   cnt_d = cnt_q + ADD_LEN'(1);
  end

  // Storage is not reset; occupancy alone defines valid contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= fifo_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      fifo_out_q <= '0;
      flag_q     <= 1'b0;
      reg_q      <= '0;
      cnt_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      fifo_out_q <= fifo_out_d;
      flag_q     <= flag_d;
      reg_q      <= reg_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dma_buffer_datapath.sv
// Directed bench for dma_buffer_datapath; FIFO read data is checked by a
// monitor against a queue of expected words pushed by the stimulus.
module tb_dma_buffer_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_en, fifo_wr_rd, fifo_clr, fifo_old_add_flag;
  logic [15:0] fifo_in, fifo_out;
  logic        full, empty, empty_partial;
  logic        reg_en, reg_clr;
  logic [15:0] reg_in, reg_out;
  logic        cnt_en, cnt_load, cnt_clr;
  logic [15:0] cnt_in, cnt;
  logic        end_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  dma_buffer_datapath dut (
    .clk(clk), .rst(rst),
    .fifo_en(fifo_en), .fifo_wr_rd(fifo_wr_rd), .fifo_clr(fifo_clr),
    .fifo_old_add_flag(fifo_old_add_flag), .fifo_in(fifo_in),
    .fifo_out(fifo_out), .full(full), .empty(empty),
    .empty_partial(empty_partial),
    .reg_en(reg_en), .reg_clr(reg_clr), .reg_in(reg_in), .reg_out(reg_out),
    .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_clr(cnt_clr),
    .cnt_in(cnt_in), .cnt(cnt), .end_cnt(end_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every read strobe presented at an edge yields one fifo_out sample.
  always @(posedge clk) begin
    if (rst && fifo_en && !fifo_wr_rd && !fifo_old_add_flag && !fifo_clr) begin
      #1;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got 0x%0h expected none", fifo_out);
      end else begin
        check("sb_read", 32'(fifo_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [15:0] d);
    fifo_en = 1'b1; fifo_wr_rd = 1'b1; fifo_in = d;
    cyc();
    fifo_en = 1'b0;
  endtask

  task automatic fifo_read(input logic [15:0] e);
    fifo_en = 1'b1; fifo_wr_rd = 1'b0;
    exp_q.push_back(e);
    cyc();
    fifo_en = 1'b0;
  endtask

  task automatic retry(input logic wr);
    fifo_en = 1'b0; fifo_wr_rd = wr; fifo_old_add_flag = 1'b1;
    cyc();
    cyc();
    fifo_old_add_flag = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b0;
    fifo_en = 0; fifo_wr_rd = 0; fifo_clr = 0; fifo_old_add_flag = 0; fifo_in = '0;
    reg_en = 0; reg_clr = 0; reg_in = '0;
    cnt_en = 0; cnt_load = 0; cnt_clr = 0; cnt_in = '0;
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_epart", 32'(empty_partial), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_endcnt", 32'(end_cnt), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_reg", 32'(reg_out), 32'd0);
    check("rst_fout", 32'(fifo_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // Fill to full, overflow ignored, drain in order.
    for (int i = 1; i <= 32; i++) begin
      if (i == 32) check("not_full_31", 32'(full), 32'd0);
      fifo_write(16'(i));
    end
    check("full_32", 32'(full), 32'd1);
    fifo_write(16'hFFFF);
    check("full_hold", 32'(full), 32'd1);
    for (int i = 1; i <= 32; i++) fifo_read(16'(i));
    check("empty_drain", 32'(empty), 32'd1);
    check("not_full_drain", 32'(full), 32'd0);

    // Partial-empty threshold at 4 words.
    for (int i = 0; i < 5; i++) fifo_write(16'h0100 + 16'(i));
    check("epart_occ5", 32'(empty_partial), 32'd0);
    fifo_read(16'h0100);
    check("epart_occ4", 32'(empty_partial), 32'd1);
    for (int i = 1; i < 5; i++) fifo_read(16'h0100 + 16'(i));
    check("empty_after_part", 32'(empty), 32'd1);

    // Read while empty leaves fifo_out unchanged.
    fifo_read(16'h0104);

    // Write retry overwrites the last written word.
    fifo_write(16'hAAAA);
    fifo_write(16'hBBBB);
    retry(1'b1);
    check("wretry_not_empty", 32'(empty), 32'd0);
    fifo_write(16'hCCCC);
    fifo_read(16'hAAAA);
    fifo_read(16'hCCCC);
    check("wretry_empty", 32'(empty), 32'd1);

    // Read retry replays the last read word.
    fifo_write(16'h5555);
    fifo_read(16'h5555);
    check("rretry_pre_empty", 32'(empty), 32'd1);
    retry(1'b0);
    check("rretry_not_empty", 32'(empty), 32'd0);
    fifo_read(16'h5555);
    check("rretry_empty", 32'(empty), 32'd1);

    // Flush wins over a simultaneous write.
    fifo_write(16'h7777);
    fifo_read(16'h7777);
    fifo_write(16'h8888);
    fifo_clr = 1'b1; fifo_en = 1'b1; fifo_wr_rd = 1'b1; fifo_in = 16'h9999;
    cyc();
    fifo_clr = 1'b0; fifo_en = 1'b0;
    check("clr_fout", 32'(fifo_out), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);

    // Counter: load, count through wrap, priorities.
    cnt_load = 1; cnt_in = 16'hFFFE; cyc(); cnt_load = 0;
    check("cnt_load", 32'(cnt), 32'hFFFE);
    check("cnt_load_end", 32'(end_cnt), 32'd0);
    cnt_en = 1; cyc();
    check("cnt_ffff", 32'(cnt), 32'hFFFF);
    check("cnt_end1", 32'(end_cnt), 32'd1);
    cyc(); cnt_en = 0;
    check("cnt_wrap", 32'(cnt), 32'h0000);
    check("cnt_end0", 32'(end_cnt), 32'd0);
    cnt_load = 1; cnt_en = 1; cnt_in = 16'h0010; cyc(); cnt_load = 0; cnt_en = 0;
    check("cnt_load_over_en", 32'(cnt), 32'h0010);
    cyc();
    check("cnt_hold", 32'(cnt), 32'h0010);
    cnt_clr = 1; cnt_load = 1; cnt_in = 16'h1234; cyc(); cnt_clr = 0; cnt_load = 0;
    check("cnt_clr_wins", 32'(cnt), 32'h0000);

    // Register load, hold, clear priority.
    reg_in = 16'h1234; reg_en = 1; cyc(); reg_en = 0;
    check("reg_load", 32'(reg_out), 32'h1234);
    reg_in = 16'h5678; cyc();
    check("reg_hold", 32'(reg_out), 32'h1234);
    reg_clr = 1; reg_en = 1; cyc(); reg_clr = 0; reg_en = 0;
    check("reg_clr_wins", 32'(reg_out), 32'h0000);

    // Asynchronous reset mid-transfer.
    for (int i = 0; i < 10; i++) fifo_write(16'h0A00 + 16'(i));
    cnt_load = 1; cnt_in = 16'h0007; reg_en = 1; reg_in = 16'h00C3;
    fifo_en = 1; fifo_wr_rd = 0;
    exp_q.push_back(16'h0A00);
    cyc();
    cnt_load = 0; reg_en = 0; fifo_en = 0;
    check("pre_rst_cnt", 32'(cnt), 32'h0007);
    #2 rst = 1'b0;
    #1;
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_epart", 32'(empty_partial), 32'd1);
    check("arst_full", 32'(full), 32'd0);
    check("arst_cnt", 32'(cnt), 32'd0);
    check("arst_reg", 32'(reg_out), 32'd0);
    check("arst_fout", 32'(fifo_out), 32'd0);
    check("arst_endcnt", 32'(end_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // First edge after reset is honoured normally.
    fifo_write(16'h9999);
    check("post_rst_not_empty", 32'(empty), 32'd0);
    fifo_read(16'h9999);
    check("post_rst_empty", 32'(empty), 32'd1);

    cyc();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
